// File: rtl/tl_line_master.sv
// tl_line_master: turns one 512-bit cache-line refill/writeback into TL-UH Get / PutFullData
// traffic and folds the D-channel reply back into a single line-wide response.
module tl_line_master #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int BEATS     = 8,
    parameter int LINE_LGSZ = 6,
    parameter int SOURCE_ID = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W*BEATS-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic [DATA_W*BEATS-1:0] resp_rdata,
    output logic                    resp_denied,
    output logic                    resp_corrupt,
    output logic                    proto_err,
    output logic [2:0]              a_opcode,
    output logic [2:0]              a_param,
    output logic [2:0]              a_size,
    output logic [3:0]              a_source,
    output logic [ADDR_W-1:0]       a_address,
    output logic [7:0]              a_mask,
    output logic [DATA_W-1:0]       a_data,
    output logic                    a_valid,
    input  logic                    a_ready,
    input  logic [2:0]              d_opcode,
    input  logic [1:0]              d_param,
    input  logic [2:0]              d_size,
    input  logic [3:0]              d_source,
    input  logic [1:0]              d_sink,
    input  logic                    d_denied,
    input  logic [DATA_W-1:0]       d_data,
    input  logic                    d_corrupt,
    input  logic                    d_valid,
    output logic                    d_ready
);
    localparam int LINE_W = DATA_W * BEATS;
    localparam int CW = $clog2(BEATS);
    typedef enum logic [2:0] {IDLE, A_GET, A_PUT, D_WAIT, RESP} state_t;
    state_t state_q;
    logic write_q, denied_q, corrupt_q, proto_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q, rdata_q;
    logic [CW-1:0] cnt_q;
    logic a_st, last_beat, d_bad, unused;
    assign unused = ^{d_param, d_size, d_sink, req_addr[LINE_LGSZ-1:0]};
    assign a_st = state_q == A_GET || state_q == A_PUT;
    assign last_beat = cnt_q == CW'(BEATS - 1);
    assign d_bad = d_source != 4'(SOURCE_ID) || d_opcode != {2'b00, ~write_q};
    // A fields are pure decodes of registered state, so they stay stable through a stall
    assign req_ready = state_q == IDLE;
    assign a_valid = a_st;
    assign a_opcode = state_q == A_GET ? 3'd4 : 3'd0;
    assign a_param = 3'd0;
    assign a_size = a_st ? 3'(LINE_LGSZ) : 3'd0;
    assign a_source = a_st ? 4'(SOURCE_ID) : 4'd0;
    assign a_mask = a_st ? 8'hFF : 8'h00;
    assign a_address = a_st ? addr_q : '0;
    assign a_data = state_q == A_PUT ? wdata_q[DATA_W*cnt_q +: DATA_W] : '0;
    assign d_ready = state_q == D_WAIT;
    assign resp_valid = state_q == RESP;
    assign resp_write = write_q;
    assign resp_rdata = rdata_q;
    assign resp_denied = denied_q;
    assign resp_corrupt = corrupt_q;
    assign proto_err = proto_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q <= '0;
            denied_q <= 1'b0;
            corrupt_q <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    write_q <= req_write;
                    addr_q <= {req_addr[ADDR_W-1:LINE_LGSZ], {LINE_LGSZ{1'b0}}};
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    cnt_q <= '0;
                    denied_q <= 1'b0;
                    corrupt_q <= 1'b0;
                    state_q <= req_write ? A_PUT : A_GET;
                end
                A_GET: if (a_ready) state_q <= D_WAIT;
                A_PUT: if (a_ready) begin
                    cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
                    if (last_beat) state_q <= D_WAIT;
                end
                D_WAIT: if (d_valid) begin
                    denied_q <= denied_q | d_denied;
                    corrupt_q <= corrupt_q | d_corrupt;
                    if (d_bad) proto_q <= 1'b1;
                    if (write_q) state_q <= RESP;
                    else begin
                        rdata_q[DATA_W*cnt_q +: DATA_W] <= d_data;
                        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
                        if (last_beat) state_q <= RESP;
                    end
                end
                RESP: if (resp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_line_master.sv
// tb_tl_line_master: random-timing TL-UH slave plus a line-level memory model checking tl_line_master.
module tb_tl_line_master;
    typedef logic [148:0] abeat_t;
    typedef struct {
        logic [2:0] op;
        logic [3:0] src;
        logic den;
        logic cor;
        logic [63:0] data;
    } dbeat_t;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 0, req_write = 0, resp_ready = 0, a_ready = 0, d_valid = 0;
    logic [63:0] req_addr = '0, d_data = '0;
    logic [511:0] req_wdata = '0;
    logic [2:0] d_opcode = '0, d_size = '0;
    logic [1:0] d_param = '0, d_sink = '0;
    logic [3:0] d_source = '0;
    logic d_denied = 0, d_corrupt = 0;
    logic req_ready, resp_valid, resp_write, resp_denied, resp_corrupt, proto_err, a_valid, d_ready;
    logic [511:0] resp_rdata;
    logic [2:0] a_opcode, a_param, a_size;
    logic [3:0] a_source;
    logic [63:0] a_address, a_data;
    logic [7:0] a_mask;
    logic [63:0] mem [0:4095];
    logic [63:0] ref_mem [0:4095];
    abeat_t a_log [$];
    dbeat_t dq [$];
    abeat_t held;
    int n_tests = 0, n_fail = 0, cyc = 0, last_d = -1, put_cnt = 0, stall_n = 0, stall_beat = -1;
    bit pend = 0, inj = 0, exp_den = 0, exp_cor = 0, exp_proto = 0;

    tl_line_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_write(resp_write), .resp_rdata(resp_rdata), .resp_denied(resp_denied),
        .resp_corrupt(resp_corrupt), .proto_err(proto_err), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_valid(a_valid), .a_ready(a_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
        .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt), .d_valid(d_valid), .d_ready(d_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic abeat_t cur_a();
        return {a_opcode, a_param, a_size, a_source, a_mask, a_address, a_data};
    endfunction

    function automatic logic [156:0] outs();
        return {req_ready, resp_valid, resp_write, resp_denied, resp_corrupt, proto_err, a_valid, d_ready,
                a_opcode, a_param, a_size, a_source, a_mask, a_address, a_data};
    endfunction

    function automatic void push_d(input logic [2:0] op, input logic [63:0] data);
        dbeat_t b;
        b.op = op; b.src = 4'd0; b.den = 1'b0; b.cor = ($urandom % 16) == 0; b.data = data;
        if (inj) begin
            b.src = 4'd5; b.den = 1'b1; inj = 0;
        end
        dq.push_back(b);
    endfunction

    // Slave: decides this cycle's ready/valid on the falling edge; handshakes land on the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            put_cnt = 0; dq.delete(); pend = 0; a_ready = 0; d_valid = 0;
        end else begin
            if (pend) chk("a_stable", 512'({a_valid, cur_a()}), 512'({1'b1, held}));
            if (stall_n > 0 && a_valid && a_opcode == 3'd0 && put_cnt == stall_beat) begin
                a_ready = 0; stall_n--;
            end else a_ready = ($urandom % 4) != 0;
            if (a_valid && a_ready) begin
                a_log.push_back(cur_a());
                if (a_opcode == 3'd4) begin
                    for (int i = 0; i < 8; i++) push_d(3'd1, mem[12'(a_address[14:3] + 12'(i))]);
                end else begin
                    mem[12'(a_address[14:3] + 12'(put_cnt))] = a_data;
                    put_cnt++;
                    if (put_cnt == 8) begin
                        put_cnt = 0; push_d(3'd0, 64'd0);
                    end
                end
            end
            pend = a_valid && !a_ready;
            held = cur_a();
            if (dq.size() > 0 && (d_valid || ($urandom % 3) != 0)) begin
                d_valid = 1; d_opcode = dq[0].op; d_source = dq[0].src; d_denied = dq[0].den;
                d_corrupt = dq[0].cor; d_data = dq[0].data;
                d_param = 2'($urandom); d_sink = 2'($urandom); d_size = 3'd6;
            end else d_valid = 0;
            if (d_valid && d_ready) begin
                exp_den |= d_denied; exp_cor |= d_corrupt;
                if (d_source != 4'd0) exp_proto = 1;
                last_d = cyc + 1;
                void'(dq.pop_front());
            end
        end
    end

    task automatic send_req(input bit wr, input logic [63:0] addr, input logic [511:0] wd);
        int t = 0;
        a_log.delete(); exp_den = 0; exp_cor = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        chk("req_ready", 512'(req_ready), 512'(1));
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(negedge clk); #1;
        req_valid = 0;
        chk("a_latency", 512'({a_valid, req_ready}), 512'(2'b10));
    endtask

    task automatic txn(input bit wr, input logic [63:0] addr, input logic [511:0] wd, input int rdly);
        logic [511:0] exp_rd;
        logic [63:0] base;
        int t = 0;
        base = addr & ~64'h3F;
        send_req(wr, addr, wd);
        while (!resp_valid && t < 2000) begin
            @(negedge clk); #1; t++;
        end
        chk("resp_timeout", 512'(resp_valid), 512'(1));
        chk("resp_latency", 512'(cyc), 512'(last_d));
        for (int i = 0; i < 8; i++) exp_rd[64*i +: 64] = wr ? 64'd0 : ref_mem[12'(base[14:3] + 12'(i))];
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_flags", 512'({resp_write, resp_denied, resp_corrupt, proto_err}),
            512'({wr, exp_den, exp_cor, exp_proto}));
        repeat (rdly) begin
            @(negedge clk); #1;
            chk("resp_hold", 512'({resp_valid, resp_rdata[510:0]}), 512'({1'b1, exp_rd[510:0]}));
        end
        resp_ready = 1;
        @(negedge clk); #1;
        resp_ready = 0;
        chk("resp_done", 512'({resp_valid, req_ready}), 512'(2'b01));
        chk("a_count", 512'(a_log.size()), 512'(wr ? 8 : 1));
        foreach (a_log[i])
            chk("a_beat", 512'(a_log[i]), 512'({wr ? 3'd0 : 3'd4, 3'd0, 3'd6, 4'd0, 8'hFF, base,
                wr ? wd[64*i +: 64] : 64'd0}));
        if (wr) for (int i = 0; i < 8; i++) ref_mem[12'(base[14:3] + 12'(i))] = wd[64*i +: 64];
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic [511:0] wd;
        int t;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 64'(i); ref_mem[i] = 64'(i);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", 512'(outs()), 512'({1'b1, 156'd0}));
        chk("reset_rdata", resp_rdata, 512'd0);
        rst = 0;
        txn(0, 64'h1040, '0, 0);
        for (int i = 0; i < 8; i++) wd[64*i +: 64] = 64'hA0 + 64'(i);
        txn(1, 64'h200, wd, 1);
        txn(0, 64'h200, '0, 0);
        txn(1, 64'h207, rand_line(), 0);
        txn(0, 64'h207, '0, 2);
        stall_beat = 3; stall_n = 5;
        txn(1, 64'h400, rand_line(), 3);
        chk("stall_used", 512'(stall_n), 512'(0));
        txn(0, 64'h400, '0, 0);
        inj = 1;
        txn(0, 64'h40, '0, 1);
        txn(1, 64'h80, rand_line(), 0);
        for (int k = 0; k < 20; k++) begin
            if ($urandom % 2) txn(1, 64'($urandom_range(0, 4095)), rand_line(), $urandom_range(0, 3));
            else txn(0, 64'($urandom_range(0, 4095)), '0, $urandom_range(0, 3));
        end
        send_req(1, 64'h800, rand_line());
        t = 0;
        while (put_cnt < 4 && t < 200) begin
            @(negedge clk); #1; t++;
        end
        chk("put4_reached", 512'(put_cnt), 512'(4));
        rst = 1;
        #1;
        chk("midburst_rst", 512'(outs()), 512'({1'b1, 156'd0}));
        chk("midburst_rdata", resp_rdata, 512'd0);
        exp_proto = 0;
        @(negedge clk); #1;
        rst = 0;
        txn(0, 64'h1040, '0, 0);
        txn(1, 64'hC00, rand_line(), 1);
        txn(0, 64'hC00, '0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
